// File: rtl/alu_pkg.sv
// Shared constants and types for the EX-stage ALU with iterative multiply/divide.
package alu_pkg;

  // 4-bit control codes driving the single-cycle datapath
  localparam logic [3:0] CTL_ADD  = 4'b0000;
  localparam logic [3:0] CTL_SUB  = 4'b0001;
  localparam logic [3:0] CTL_AND  = 4'b0010;
  localparam logic [3:0] CTL_OR   = 4'b0011;
  localparam logic [3:0] CTL_XOR  = 4'b0100;
  localparam logic [3:0] CTL_NOR  = 4'b0101;
  localparam logic [3:0] CTL_SLL  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_MUL  = 4'b1000;
  localparam logic [3:0] CTL_DIV  = 4'b1001;
  localparam logic [3:0] CTL_MFHI = 4'b1010;
  localparam logic [3:0] CTL_MFLO = 4'b1011;

  localparam logic [5:0] FN_ADD   = 6'd0;
  localparam logic [5:0] FN_SUB   = 6'd1;
  localparam logic [5:0] FN_NOR   = 6'd2;
  localparam logic [5:0] FN_SLL   = 6'd3;
  localparam logic [5:0] FN_SLT   = 6'd4;
  localparam logic [5:0] FN_OR    = 6'd5;
  localparam logic [5:0] FN_XOR   = 6'd6;
  localparam logic [5:0] FN_AND   = 6'd7;
  localparam logic [5:0] FN_MULT  = 6'd8;
  localparam logic [5:0] FN_MULTU = 6'd9;
  localparam logic [5:0] FN_DIV   = 6'd10;
  localparam logic [5:0] FN_DIVU  = 6'd11;
  localparam logic [5:0] FN_MFHI  = 6'd12;
  localparam logic [5:0] FN_MFLO  = 6'd13;

  localparam logic [2:0] AOP_RTYPE = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_SLT   = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_MUL    = 2'd1,
    CLS_DIV    = 2'd2
  } op_class_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of main-control op class and R-type function field.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] ctl,
  output op_class_t  op_class,
  output logic       is_signed
);

  always_comb begin
    ctl       = CTL_ADD;
    op_class  = CLS_SINGLE;
    is_signed = 1'b0;
    case (alu_op)
      AOP_RTYPE: begin
        case (funct)
          FN_ADD:   ctl = CTL_ADD;
          FN_SUB:   ctl = CTL_SUB;
          FN_NOR:   ctl = CTL_NOR;
          FN_SLL:   ctl = CTL_SLL;
          FN_SLT:   ctl = CTL_SLT;
          FN_OR:    ctl = CTL_OR;
          FN_XOR:   ctl = CTL_XOR;
          FN_AND:   ctl = CTL_AND;
          FN_MULT:  begin ctl = CTL_MUL; op_class = CLS_MUL; is_signed = 1'b1; end
          FN_MULTU: begin ctl = CTL_MUL; op_class = CLS_MUL; end
          FN_DIV:   begin ctl = CTL_DIV; op_class = CLS_DIV; is_signed = 1'b1; end
          FN_DIVU:  begin ctl = CTL_DIV; op_class = CLS_DIV; end
          FN_MFHI:  ctl = CTL_MFHI;
          FN_MFLO:  ctl = CTL_MFLO;
          default:  ctl = CTL_AND;
        endcase
      end
      AOP_SUB: ctl = CTL_SUB;
      AOP_SLT: ctl = CTL_SLT;
      default: ctl = CTL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage ALU with registered result, valid/ready handshake and a
// bit-serial multiply/divide engine that owns the HI/LO registers.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       AluOp,
  input  logic [5:0]       Function,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  logic [1:0]           state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   work_reg;
  logic [WIDTH-1:0]     opnd_reg;
  logic [WIDTH-1:0]     raw_a_reg;
  logic                 neg_res_reg, sign_a_reg, div0_reg, is_div_reg;
  logic                 out_valid_reg, zero_reg, ovf_reg;
  logic [WIDTH-1:0]     result_reg, hi_reg, lo_reg;

  logic [3:0]           ctl;
  op_class_t            op_class;
  logic                 is_signed;
  logic                 accept;

  alu_op_decode u_decode (
    .alu_op    (AluOp),
    .funct     (Function),
    .ctl       (ctl),
    .op_class  (op_class),
    .is_signed (is_signed)
  );

  assign OutValid = out_valid_reg;
  assign Result   = result_reg;
  assign Zero     = zero_reg;
  assign Overflow = ovf_reg;
  assign Hi       = hi_reg;
  assign Lo       = lo_reg;
  assign Busy     = (state_reg != ST_IDLE);
  assign InReady  = (state_reg == ST_IDLE) && !rst && (!out_valid_reg || OutReady);
  assign accept   = InValid && InReady;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  always_comb begin
    sum     = A + B;
    diff    = A - B;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctl)
      CTL_ADD: begin
        alu_res = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      CTL_SUB: begin
        alu_res = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      CTL_AND:  alu_res = A & B;
      CTL_OR:   alu_res = A | B;
      CTL_XOR:  alu_res = A ^ B;
      CTL_NOR:  alu_res = ~(A | B);
      CTL_SLL:  alu_res = A << B[CNT_W-2:0];
      CTL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      CTL_MFHI: alu_res = hi_reg;
      CTL_MFLO: alu_res = lo_reg;
      default:  alu_res = '0;
    endcase
  end

  logic [WIDTH-1:0] mag_a, mag_b;
  assign mag_a = (is_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b = (is_signed && B[WIDTH-1]) ? -B : B;

  // work_reg holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, div_next;
  logic [WIDTH+1:0]     div_trial;

  always_comb begin
    mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next  = {mul_sum, work_reg[WIDTH-1:1]};
    div_trial = {1'b0, work_reg[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_reg};
    if (div_trial[WIDTH+1])
      div_next = {work_reg[2*WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_res_reg ? -work_reg : work_reg;
    quo      = work_reg[WIDTH-1:0];
    rem      = work_reg[2*WIDTH-1:WIDTH];
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      if (div0_reg) begin
        fix_hi = raw_a_reg;
        fix_lo = '1;
      end else begin
        fix_hi = sign_a_reg  ? -rem : rem;
        fix_lo = neg_res_reg ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      work_reg      <= '0;
      opnd_reg      <= '0;
      raw_a_reg     <= '0;
      neg_res_reg   <= 1'b0;
      sign_a_reg    <= 1'b0;
      div0_reg      <= 1'b0;
      is_div_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      if (out_valid_reg && OutReady)
        out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (op_class == CLS_SINGLE) begin
              out_valid_reg <= 1'b1;
              result_reg    <= alu_res;
              zero_reg      <= (alu_res == '0);
              ovf_reg       <= alu_ovf;
            end else begin
              state_reg   <= (op_class == CLS_MUL) ? ST_MUL : ST_DIV;
              cnt_reg     <= CNT_W'(WIDTH);
              is_div_reg  <= (op_class == CLS_DIV);
              opnd_reg    <= (op_class == CLS_MUL) ? mag_a : mag_b;
              work_reg    <= (op_class == CLS_MUL) ? {{WIDTH{1'b0}}, mag_b}
                                                   : {{WIDTH{1'b0}}, mag_a};
              neg_res_reg <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
              sign_a_reg  <= is_signed && A[WIDTH-1];
              div0_reg    <= (B == '0);
              raw_a_reg   <= A;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          work_reg <= (state_reg == ST_MUL) ? mul_next : div_next;
          cnt_reg  <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1))
            state_reg <= ST_FIX;
        end
        default: begin
          hi_reg        <= fix_hi;
          lo_reg        <= fix_lo;
          result_reg    <= fix_lo;
          zero_reg      <= (fix_lo == '0);
          ovf_reg       <= 1'b0;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
